// File: rtl/gb_lcd_video_gen.sv
// GameBoy LCD capture into a 2-bit frame buffer, re-read on a fixed raster with sync and palette.
// Optional macro GB_VIDGEN_GREEN_EN selects the DMG green palette instead of grey.
module gb_lcd_video_gen #(
  parameter int CE_DIV     = 4,
  parameter int H_TOTAL    = 384,
  parameter int V_TOTAL    = 262,
  parameter int H_START    = 112,
  parameter int V_START    = 59,
  parameter int H_SYNC_POS = 8,
  parameter int H_SYNC_LEN = 28,
  parameter int V_SYNC_POS = 2,
  parameter int V_SYNC_LEN = 3,
  parameter int ACT_W      = 160,
  parameter int ACT_H      = 144
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       lcd_ce,
  input  logic [1:0] lcd_data,
  input  logic       lcd_vsync,
  input  logic       lcd_on,
  output logic       ce_pix,
  output logic [5:0] R,
  output logic [5:0] G,
  output logic [5:0] B,
  output logic       HSync,
  output logic       VSync,
  output logic       line_start
);

  localparam int BUF_DEPTH = ACT_W * ACT_H;
  localparam int AW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(BUF_DEPTH);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(CE_DIV - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_START);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_START + ACT_W - 1);
  localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_START);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_START + ACT_H - 1);
  localparam logic [HW-1:0] HS_FIRST    = HW'(H_SYNC_POS);
  localparam logic [HW-1:0] HS_END      = HW'(H_SYNC_POS + H_SYNC_LEN);
  localparam logic [VW-1:0] VS_FIRST    = VW'(V_SYNC_POS);
  localparam logic [VW-1:0] VS_END      = VW'(V_SYNC_POS + V_SYNC_LEN);
  localparam logic [AW-1:0] BUF_N       = AW'(BUF_DEPTH);

  // ---------------- pixel divider ----------------
  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= tick;
      div    <= tick ? '0 : div + 1'b1;
    end
  end

  // ---------------- raster ----------------
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [AW-1:0] rd_ptr;
  logic          frame_on;
  logic          h_act;
  logic          v_act;
  logic          active;
  logic          hs_now;
  logic          vs_now;

  assign h_act  = (hc >= H_ACT_FIRST) && (hc <= H_ACT_LAST);
  assign v_act  = (vc >= V_ACT_FIRST) && (vc <= V_ACT_LAST);
  assign active = h_act && v_act;
  assign hs_now = (hc >= HS_FIRST) && (hc < HS_END);
  assign vs_now = (vc >= VS_FIRST) && (vc < VS_END);

  // rd_ptr counts active pixels already passed this frame, so it equals the
  // buffer index of the current pixel whenever that pixel is active.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc       <= '0;
      vc       <= '0;
      rd_ptr   <= '0;
      frame_on <= 1'b0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
      if (vc == '0) begin
        rd_ptr <= '0;
      end else if (active) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // lcd_on is decided once per frame to avoid tearing the blank screen
      if ((hc == '0) && (vc == '0)) begin
        frame_on <= lcd_on;
      end
    end
  end

  // ---------------- write side ----------------
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wr_base;
  logic          vs_prev;
  logic          vs_edge;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign vs_edge = lcd_vsync & ~vs_prev;
  assign wr_base = vs_edge ? '0 : wr_addr;
  assign wr_en   = lcd_on & lcd_ce & (wr_base < BUF_N);
  assign wr_idx  = wr_base[IW-1:0];
  assign rd_idx  = (rd_ptr < BUF_N) ? rd_ptr[IW-1:0] : '0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_addr <= '0;
      vs_prev <= 1'b0;
    end else begin
      vs_prev <= lcd_vsync;
      if (wr_en) begin
        wr_addr <= wr_base + 1'b1;
      end else if (lcd_on && vs_edge) begin
        wr_addr <= '0;
      end
    end
  end

  // ---------------- frame buffer ----------------
  logic [1:0] mem [BUF_DEPTH];
  logic [1:0] rd_q;

  // Read and write share one edge; a same-address collision returns old data.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[wr_idx] <= lcd_data;
    end
    rd_q <= mem[rd_idx];
  end

  // ---------------- palette ----------------
  function automatic logic [17:0] palette(input logic [1:0] s);
    logic [17:0] c;
`ifdef GB_VIDGEN_GREEN_EN
    case (s)
      2'd0:    c = {6'd38, 6'd47, 6'd4};
      2'd1:    c = {6'd34, 6'd43, 6'd4};
      2'd2:    c = {6'd12, 6'd24, 6'd12};
      default: c = {6'd3, 6'd14, 6'd3};
    endcase
`else
    case (s)
      2'd0:    c = {6'd63, 6'd63, 6'd63};
      2'd1:    c = {6'd42, 6'd42, 6'd42};
      2'd2:    c = {6'd21, 6'd21, 6'd21};
      default: c = {6'd0, 6'd0, 6'd0};
    endcase
`endif
    return c;
  endfunction

  // ---------------- output pipeline ----------------
  logic        ce_s1;
  logic        act_s1;
  logic        on_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic [1:0]  shade;
  logic [17:0] rgb_next;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_s1  <= 1'b0;
      act_s1 <= 1'b0;
      on_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
    end else begin
      ce_s1 <= ce_pix;
      if (ce_pix) begin
        act_s1 <= active;
        on_s1  <= frame_on;
        hs_s1  <= hs_now;
        vs_s1  <= vs_now;
      end
    end
  end

  always_comb begin
    shade    = 2'd0;
    rgb_next = 18'd0;
    if (act_s1 && on_s1) begin
      shade = rd_q;
    end
    if (act_s1) begin
      rgb_next = palette(shade);
    end
  end

  // Stage 2 lands every output together two cycles after the advancing ce_pix.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      R          <= '0;
      G          <= '0;
      B          <= '0;
      HSync      <= 1'b0;
      VSync      <= 1'b0;
      line_start <= 1'b1;
    end else if (ce_s1) begin
      R          <= rgb_next[17:12];
      G          <= rgb_next[11:6];
      B          <= rgb_next[5:0];
      HSync      <= hs_s1;
      VSync      <= vs_s1;
      line_start <= ~act_s1;
    end
  end

endmodule

// File: tb/tb_gb_lcd_video_gen.sv
// Bench for gb_lcd_video_gen: randomized LCD writes, raster expectations from a frame-level model.
module tb_gb_lcd_video_gen;

  localparam int CE_DIV     = 4;
  localparam int H_TOTAL    = 40;
  localparam int V_TOTAL    = 20;
  localparam int H_START    = 12;
  localparam int V_START    = 6;
  localparam int H_SYNC_POS = 2;
  localparam int H_SYNC_LEN = 5;
  localparam int V_SYNC_POS = 1;
  localparam int V_SYNC_LEN = 2;
  localparam int ACT_W      = 16;
  localparam int ACT_H      = 8;
  localparam int NPIX       = ACT_W * ACT_H;
  localparam int FRAME      = H_TOTAL * V_TOTAL;
  localparam int W          = 86;

  // ---------------- clock / reset ----------------
  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_ce = 1'b0;
  logic [1:0] lcd_data = 2'd0;
  logic       lcd_vsync = 1'b0;
  logic       lcd_on = 1'b0;
  logic       ce_pix;
  logic [5:0] R;
  logic [5:0] G;
  logic [5:0] B;
  logic       HSync;
  logic       VSync;
  logic       line_start;

  always #5 clk_sys = ~clk_sys;

  int cyc;
  always @(posedge clk_sys) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  gb_lcd_video_gen #(
    .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_START(H_START), .V_START(V_START),
    .H_SYNC_POS(H_SYNC_POS), .H_SYNC_LEN(H_SYNC_LEN),
    .V_SYNC_POS(V_SYNC_POS), .V_SYNC_LEN(V_SYNC_LEN),
    .ACT_W(ACT_W), .ACT_H(ACT_H)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .lcd_ce(lcd_ce), .lcd_data(lcd_data),
    .lcd_vsync(lcd_vsync), .lcd_on(lcd_on), .ce_pix(ce_pix),
    .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .line_start(line_start)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [1:0] m_mem [NPIX];
  bit         m_known [NPIX];
  int         m_wr_ptr = 0;
  bit         m_prev_vs = 1'b0;
  bit         m_frame_on = 1'b0;

  function automatic logic [17:0] pal(input logic [1:0] s);
    logic [5:0] v;
`ifdef GB_VIDGEN_GREEN_EN
    case (s)
      2'd0:    return {6'd38, 6'd47, 6'd4};
      2'd1:    return {6'd34, 6'd43, 6'd4};
      2'd2:    return {6'd12, 6'd24, 6'd12};
      default: return {6'd3, 6'd14, 6'd3};
    endcase
`else
    v = 6'(63 - 21 * int'(s));
    return {v, v, v};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic lcd_cycle(input bit ce, input logic [1:0] d, input bit vs);
    bit edge_seen;
    @(posedge clk_sys); #1;
    lcd_ce = ce;
    lcd_data = d;
    lcd_vsync = vs;
    @(posedge clk_sys);
    edge_seen = vs && !m_prev_vs;
    m_prev_vs = vs;
    if (lcd_on) begin
      if (edge_seen) m_wr_ptr = 0;
      if (ce && m_wr_ptr < NPIX) begin
        m_mem[m_wr_ptr] = d;
        m_known[m_wr_ptr] = 1'b1;
        m_wr_ptr++;
      end
    end
    #1 lcd_ce = 1'b0;
  endtask

  task automatic idle_rand(input int max_idle);
    repeat ($urandom_range(0, max_idle)) @(posedge clk_sys);
  endtask

  task automatic set_on(input bit v);
    @(posedge clk_sys); #1;
    lcd_on = v;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(posedge clk_sys);
  endtask

  // ---------------- expectation producer ----------------
  // Layout: due[85:54] k[53:22] known[21] rgb[20:3] hs[2] vs[1] ls[0]
  logic [W-1:0] exp_q[$];

  always @(negedge clk_sys) begin
    int k, idx, hc, vc, px;
    bit act, hs, vs, known;
    logic [1:0] sh;
    logic [17:0] rgb;
    if (!reset && cyc > 0 && (cyc % CE_DIV) == 0) begin
      k   = cyc / CE_DIV;
      idx = k % FRAME;
      hc  = idx % H_TOTAL;
      vc  = idx / H_TOTAL;
      if (idx == 1) m_frame_on = lcd_on;
      act = (hc >= H_START) && (hc < H_START + ACT_W) && (vc >= V_START) && (vc < V_START + ACT_H);
      hs  = (hc >= H_SYNC_POS) && (hc < H_SYNC_POS + H_SYNC_LEN);
      vs  = (vc >= V_SYNC_POS) && (vc < V_SYNC_POS + V_SYNC_LEN);
      known = 1'b1;
      rgb = 18'd0;
      sh = 2'd0;
      if (act) begin
        if (m_frame_on) begin
          px = (vc - V_START) * ACT_W + (hc - H_START);
          sh = m_mem[px];
          known = m_known[px];
        end
        rgb = pal(sh);
      end
      exp_q.push_back({32'(cyc + 2), 32'(k), known, rgb, hs, vs, !act});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [20:0]  cur_exp = {18'd0, 1'b0, 1'b0, 1'b1};
  bit           cur_known = 1'b1;
  int           act_cnt = 0;
  int           hs_cnt = 0;
  int           vs_cnt = 0;

  always @(negedge clk_sys) begin
    logic [W-1:0] e;
    logic [20:0]  got;
    int           kk;
    bit           exp_ce;
    if (!reset) begin
      exp_ce = (cyc > 0) && ((cyc % CE_DIV) == 0);
      checks++;
      if (ce_pix !== exp_ce) begin
        failures++;
        $display("FAIL ce_pix cyc=%0d got=%0b exp=%0b", cyc, ce_pix, exp_ce);
      end
      if (exp_q.size() > 0 && exp_q[0][85:54] == 32'(cyc)) begin
        e = exp_q.pop_front();
        cur_exp = e[20:0];
        cur_known = e[21];
        kk = int'(e[53:22]);
        if (kk >= FRAME && kk < 2 * FRAME) begin
          if (line_start === 1'b0) act_cnt++;
          if (HSync === 1'b1) hs_cnt++;
          if (VSync === 1'b1) vs_cnt++;
        end
      end
      got = {R, G, B, HSync, VSync, line_start};
      checks++;
      if (cur_known ? (got !== cur_exp) : (got[2:0] !== cur_exp[2:0])) begin
        failures++;
        $display("FAIL video cyc=%0d got rgb=%0d/%0d/%0d hs=%0b vs=%0b ls=%0b exp rgb=%0d/%0d/%0d hs=%0b vs=%0b ls=%0b",
                 cyc, R, G, B, HSync, VSync, line_start,
                 cur_exp[20:15], cur_exp[14:9], cur_exp[8:3], cur_exp[2], cur_exp[1], cur_exp[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(posedge clk_sys);
    #1 reset = 1'b0;

    // frame 0 is blank (lcd_on low at its start); load shade = x mod 4
    wait_cyc(100);
    set_on(1'b1);
    lcd_cycle(1'b0, 2'd0, 1'b1);
    lcd_cycle(1'b0, 2'd0, 1'b0);
    for (int x = 0; x < NPIX; x++) begin
      lcd_cycle(1'b1, 2'(x % 4), 1'b0);
      idle_rand(2);
    end

    // overflow: NPIX+5 strobes, last 5 dropped; then vsync with a shade-3 strobe
    wait_cyc(5600);
    lcd_cycle(1'b0, 2'd0, 1'b1);
    lcd_cycle(1'b0, 2'd0, 1'b0);
    for (int i = 0; i < NPIX + 5; i++) begin
      lcd_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      idle_rand(1);
    end
    lcd_cycle(1'b1, 2'd3, 1'b1);
    lcd_cycle(1'b0, 2'd0, 1'b0);

    // writes racing the frame-2 readout
    wait_cyc(7300);
    for (int i = 0; i < 40; i++) begin
      lcd_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      idle_rand(3);
    end

    // LCD off: frame 3 white, strobes and vsync ignored
    wait_cyc(9000);
    set_on(1'b0);
    for (int i = 0; i < 10; i++) begin
      lcd_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      idle_rand(2);
    end
    lcd_cycle(1'b0, 2'd0, 1'b1);
    lcd_cycle(1'b0, 2'd0, 1'b0);

    // LCD back on: write pointer resumes where it was held
    wait_cyc(11000);
    set_on(1'b1);
    wait_cyc(11100);
    for (int i = 0; i < 5; i++) begin
      lcd_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      idle_rand(2);
    end

    wait_cyc(16100);
    @(posedge clk_sys); #1;

    checks++;
    if (act_cnt != NPIX) begin
      failures++;
      $display("FAIL active_count got=%0d exp=%0d", act_cnt, NPIX);
    end
    checks++;
    if (hs_cnt != H_SYNC_LEN * V_TOTAL) begin
      failures++;
      $display("FAIL hsync_count got=%0d exp=%0d", hs_cnt, H_SYNC_LEN * V_TOTAL);
    end
    checks++;
    if (vs_cnt != V_SYNC_LEN * H_TOTAL) begin
      failures++;
      $display("FAIL vsync_count got=%0d exp=%0d", vs_cnt, V_SYNC_LEN * H_TOTAL);
    end
    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp<=1", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit=200000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
